// File: rtl/bk_cmd_sequencer.sv
// Front-end sequencer for bkProcessor: buffers tagged host commands, issues them
// one at a time with a fixed hold latency, and returns tagged results.
module bk_cmd_sequencer #(
  parameter int         DEPTH    = 4,
  parameter int         TAG_W    = 2,
  parameter int         PROC_LAT = 2,
  parameter logic [6:0] NOP_CMD  = 7'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_cmd,
  input  logic [7:0]       in_d1,
  input  logic [7:0]       in_d2,
  input  logic [7:0]       in_d3,
  input  logic [TAG_W-1:0] in_tag,
  output logic [6:0]       proc_cmd,
  output logic [7:0]       proc_d1,
  output logic [7:0]       proc_d2,
  output logic [7:0]       proc_d3,
  input  logic [7:0]       proc_dout_low,
  input  logic [7:0]       proc_dout_high,
  input  logic             proc_zero,
  input  logic             proc_error,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      out_result,
  output logic             out_zero,
  output logic             out_error,
  output logic             busy,
  output logic [7:0]       err_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = (PROC_LAT > 1) ? $clog2(PROC_LAT + 1) : 1;
  localparam int EW = TAG_W + 7 + 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  logic [EW-1:0]    r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  state_t           r_state;
  logic [LW-1:0]    r_lat_cnt;
  logic [TAG_W-1:0] r_tag;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [EW-1:0]    w_head;

  // Readiness depends only on registered occupancy; a same-cycle pop never frees a slot early.
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == {CW{1'b0}});
  assign in_ready = !w_full;
  assign w_push   = in_valid & !w_full;
  assign w_pop    = (r_state == ST_IDLE) & !w_empty;
  assign w_head   = r_mem[r_rd_ptr];
  assign busy     = !w_empty | (r_state != ST_IDLE);

  // Command storage; entries are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_tag, in_cmd, in_d1, in_d2, in_d3};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue/wait/respond sequencer with registered processor and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_lat_cnt  <= {LW{1'b0}};
      r_tag      <= {TAG_W{1'b0}};
      proc_cmd   <= NOP_CMD;
      proc_d1    <= 8'd0;
      proc_d2    <= 8'd0;
      proc_d3    <= 8'd0;
      out_valid  <= 1'b0;
      out_tag    <= {TAG_W{1'b0}};
      out_result <= 16'd0;
      out_zero   <= 1'b0;
      out_error  <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            {r_tag, proc_cmd, proc_d1, proc_d2, proc_d3} <= w_head;
            r_lat_cnt <= LW'(PROC_LAT);
            r_state   <= ST_WAIT;
          end else begin
            proc_cmd <= NOP_CMD;
          end
        end
        ST_WAIT: begin
          if (r_lat_cnt == LW'(1)) begin
            out_result <= {proc_dout_high, proc_dout_low};
            out_zero   <= proc_zero;
            out_error  <= proc_error;
            out_tag    <= r_tag;
            out_valid  <= 1'b1;
            proc_cmd   <= NOP_CMD;
            r_lat_cnt  <= {LW{1'b0}};
            r_state    <= ST_RESP;
            if (proc_error && (err_count != 8'hFF)) begin
              err_count <= err_count + 8'd1;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt - LW'(1);
          end
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          out_valid <= 1'b0;
          proc_cmd  <= NOP_CMD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bk_cmd_sequencer.sv
// Scoreboard bench for bk_cmd_sequencer with a behavioural bkProcessor stub.
module tb_bk_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_cmd;
  logic [7:0]  in_d1, in_d2, in_d3;
  logic [1:0]  in_tag;
  logic [6:0]  proc_cmd;
  logic [7:0]  proc_d1, proc_d2, proc_d3;
  logic [7:0]  proc_dout_low, proc_dout_high;
  logic        proc_zero, proc_error;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_tag;
  logic [15:0] out_result;
  logic        out_zero, out_error;
  logic        busy;
  logic [7:0]  err_count;

  typedef struct packed {
    logic [1:0]  tag;
    logic [15:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_res  = 0;

  bk_cmd_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_d1(in_d1), .in_d2(in_d2), .in_d3(in_d3), .in_tag(in_tag),
    .proc_cmd(proc_cmd), .proc_d1(proc_d1), .proc_d2(proc_d2), .proc_d3(proc_d3),
    .proc_dout_low(proc_dout_low), .proc_dout_high(proc_dout_high),
    .proc_zero(proc_zero), .proc_error(proc_error),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_result(out_result), .out_zero(out_zero), .out_error(out_error),
    .busy(busy), .err_count(err_count)
  );

  // Processor stub
  assign proc_dout_high = proc_d2;
  assign proc_dout_low  = proc_d1 ^ proc_d3;
  assign proc_zero      = (proc_dout_high == 8'h00) && (proc_dout_low == 8'h00);
  assign proc_error     = (proc_cmd[2:0] == 3'b111);

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] tag, input logic [6:0] cmd,
                                 input logic [7:0] d1, d2, d3);
    exp_t e;
    e.tag  = tag;
    e.res  = {d2, d1 ^ d3};
    e.zero = (d2 == 8'h00) && ((d1 ^ d3) == 8'h00);
    e.err  = (cmd[2:0] == 3'b111);
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: a handshake seen at the negedge completes at the following posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t got;
      got = '{tag: out_tag, res: out_result, zero: out_zero, err: out_error};
      n_vec++;
      n_res++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_result: got %0h expected none", got);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (got !== e) begin
          n_miss++;
          $display("FAIL result: got %0h expected %0h", got, e);
        end
      end
    end
  end

  task automatic try_push(input logic [1:0] tag, input logic [6:0] cmd,
                          input logic [7:0] d1, d2, d3, output bit acc);
    in_valid = 1'b1; in_tag = tag; in_cmd = cmd; in_d1 = d1; in_d2 = d2; in_d3 = d3;
    @(negedge clk);
    acc = in_ready;
    if (acc) sb.push_back(model(tag, cmd, d1, d2, d3));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] tag, input logic [6:0] cmd,
                      input logic [7:0] d1, d2, d3);
    bit acc = 1'b0;
    int tries = 0;
    while (!acc && tries < 100) begin
      try_push(tag, cmd, d1, d2, d3, acc);
      tries++;
    end
    if (!acc) check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 50) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic wait_drain(input string nm);
    int cyc = 0;
    bit early = 1'b0;
    while ((sb.size() != 0 || busy) && cyc < 3000) begin
      @(posedge clk); #1;
      if (!busy && sb.size() != 0) early = 1'b1;
      cyc++;
    end
    check({nm, "_drained"}, {30'd0, sb.size() == 0, busy}, 32'h2);
    check({nm, "_busy_early"}, {31'd0, early}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   edges;
    bit   acc;
    int   n_acc;
    bit   bp_ok;
    logic [15:0] hold_res;
    logic [1:0]  hold_tag;
    logic [6:0]  rc;
    logic [7:0]  r1, r2, r3;
    int   res_base;

    rst = 1'b1; in_valid = 1'b0; in_cmd = 7'd0; in_d1 = 8'd0; in_d2 = 8'd0;
    in_d3 = 8'd0; in_tag = 2'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_outputs", {out_tag, out_result, out_zero, out_error, proc_cmd}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);

    // Single command: latency 3 edges after acceptance
    try_push(2'd1, 7'b0001110, 8'h0F, 8'h12, 8'hF0, acc);
    check("single_acc", {31'd0, acc}, 32'd1);
    wait_valid(edges);
    check("single_latency", edges, 32'd3);
    check("single_result", {16'd0, out_result}, 32'h12FF);
    wait_drain("single");

    // FIFO fill with out_ready low: first command in flight, four more fill the FIFO
    out_ready = 1'b0;
    send(2'd3, 7'h11, 8'h01, 8'h02, 8'h03);
    @(posedge clk); #1;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      try_push(2'(i), 7'(8'h20 + i), 8'(i), 8'(i * 3), 8'hA5, acc);
      if (acc) n_acc++;
    end
    check("fill_accepted", n_acc, 32'd4);
    check("fill_in_ready", {31'd0, in_ready}, 32'd0);
    check("fill_busy", {31'd0, busy}, 32'd1);
    out_ready = 1'b1;
    wait_drain("fill");

    // Backpressure in RESP
    out_ready = 1'b0;
    send(2'd1, 7'h13, 8'h44, 8'h55, 8'h66);
    send(2'd2, 7'h15, 8'h77, 8'h88, 8'h99);
    wait_valid(edges);
    hold_res = out_result; hold_tag = out_tag;
    bp_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!out_valid || out_result !== hold_res || out_tag !== hold_tag ||
          proc_cmd !== 7'd0 || proc_d1 !== 8'h44) bp_ok = 1'b0;
    end
    check("bp_stable", {31'd0, bp_ok}, 32'd1);
    check("bp_result", {14'd0, hold_tag, hold_res}, {14'd0, 2'd1, 16'h5522});
    out_ready = 1'b1;
    @(posedge clk); #1;
    wait_valid(edges);
    check("bp_release_latency", edges, 32'd3);
    wait_drain("bp");

    // Error counting and zero flag
    send(2'd0, 7'h07, 8'h01, 8'h00, 8'h00);
    send(2'd1, 7'h0F, 8'h02, 8'h10, 8'h00);
    send(2'd2, 7'h7F, 8'h03, 8'h20, 8'h00);
    wait_drain("err3");
    check("err_count_3", {24'd0, err_count}, 32'd3);
    send(2'd3, 7'h00, 8'h00, 8'h00, 8'h00);
    wait_drain("zero");
    for (int i = 0; i < 252; i++) send(2'(i), 7'h27, 8'(i), 8'h01, 8'h00);
    wait_drain("err255");
    check("err_count_255", {24'd0, err_count}, 32'd255);
    send(2'd0, 7'h37, 8'h00, 8'h01, 8'h00);
    send(2'd1, 7'h47, 8'h00, 8'h02, 8'h00);
    wait_drain("errsat");
    check("err_count_sat", {24'd0, err_count}, 32'd255);

    // Reset while a command is in WAIT with two queued
    try_push(2'd0, 7'h01, 8'h11, 8'h22, 8'h33, acc);
    try_push(2'd1, 7'h02, 8'h44, 8'h55, 8'h66, acc);
    try_push(2'd2, 7'h03, 8'h77, 8'h88, 8'h99, acc);
    check("pre_rst_busy", {30'd0, busy, out_valid}, 32'h2);
    rst = 1'b1;
    sb.delete();
    res_base = n_res;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_idle", {29'd0, busy, out_valid, in_ready}, 32'd1);
    check("midrst_err_count", {24'd0, err_count}, 32'd0);
    check("midrst_proc", {17'd0, proc_cmd, proc_d1}, 32'd0);
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) edges++;
    end
    check("midrst_no_stale", edges + (n_res - res_base), 32'd0);

    // Wrap-around stream
    res_base = n_res;
    for (int i = 0; i < 20; i++) begin
      rc = 7'($urandom()); r1 = 8'($urandom()); r2 = 8'($urandom()); r3 = 8'($urandom());
      send(2'(i), rc, r1, r2, r3);
    end
    wait_drain("wrap");
    check("wrap_count", n_res - res_base, 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bk_cmd_sequencer.md
Name: bk_cmd_sequencer

Overview:
- Front-end controller for the bkProcessor datapath.
- Accepts tagged commands from a host over a valid/ready port and buffers them in a small FIFO.
- Issues one command at a time to bkProcessor, holding cmdin/din_* stable for a fixed processing latency.
- Captures dout_high/dout_low/zero/error and returns them with the tag over a valid/ready result port. Also keeps a saturating error counter.

Parameters:
- DEPTH, 4, command FIFO depth; power of 2, minimum 2.
- TAG_W, 2, width of the host tag carried with each command.
- PROC_LAT, 2, clock edges operands are held before processor outputs are sampled; minimum 1.
- NOP_CMD, 7'd0, value driven on proc_cmd while no command is in flight.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  host command valid.
- in_ready  out  1  FIFO can accept; equals !full.
- in_cmd  in  7  command for bkProcessor cmdin.
- in_d1, in_d2, in_d3  in  8 each  operands.
- in_tag  in  TAG_W  host tag.
- proc_cmd  out  7  to bkProcessor cmdin.
- proc_d1, proc_d2, proc_d3  out  8 each  to din_1, din_2, din_3.
- proc_dout_low, proc_dout_high  in  8 each  from bkProcessor.
- proc_zero, proc_error  in  1 each  from bkProcessor.
- out_valid  out  1  result valid.
- out_ready  in  1  host accepts result.
- out_tag  out  TAG_W  tag of the completed command.
- out_result  out  16  {dout_high, dout_low}.
- out_zero, out_error  out  1 each  captured flags.
- busy  out  1  high when FIFO is non-empty or state != IDLE.
- err_count  out  8  saturating count of completions with error.

Behaviour:
- Reset (rst=1 at an edge) forces:
  - FIFO empty, state IDLE, wait counter 0;
  - proc_cmd=NOP_CMD, proc_d*=0;
  - out_valid=0, out_tag=0, out_result=0, out_zero=0, out_error=0;
  - err_count=0.
  - Reset overrides everything. An in-flight command and queued commands are discarded, no result is produced, and in_ready=1 in the cycle after reset.
- FIFO:
  - Push when in_valid & in_ready; the entry is {tag, cmd, d1, d2, d3}.
  - in_ready comes from registered occupancy only, with no same-cycle bypass. When full, in_ready=0 even if a pop occurs that cycle.
  - Pointers wrap modulo DEPTH. Occupancy counter ranges 0..DEPTH.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - proc_cmd=NOP_CMD.
  - If FIFO non-empty at the edge: pop the head into issue registers (proc_* and a tag register), load counter=PROC_LAT, go to WAIT.
  - Push and pop in the same edge are both honoured.
- WAIT:
  - proc_* held constant. Counter decrements each edge.
  - At the edge where counter==1: sample the proc_* inputs into out_result/out_zero/out_error, set out_tag from the tag register, set out_valid=1, go to RESP.
  - If proc_error was sampled high, increment err_count, saturating at 255.
- RESP:
  - proc_cmd returns to NOP_CMD; proc_d* retain their last values.
  - out_* held stable while out_valid & !out_ready.
  - On out_ready at the edge: out_valid=0, go to IDLE.
  - No new command is issued until the result is accepted.
- Latency:
  - Push at edge E0 into an empty, idle block → proc_* valid after E1 → out_valid high after E(1+PROC_LAT), which is 3 edges for the default.
  - Back-to-back throughput is one command per PROC_LAT+2 cycles with out_ready tied high.
- Ordering: results are returned in FIFO order. Tags are passed through unchanged and not checked for uniqueness.
- in_* signals are ignored when in_ready=0. out_ready is ignored when out_valid=0.

Test Plan:
The bench uses a behavioural processor stub: dout_high=d2, dout_low=d1^d3, zero=(both outputs zero), error=(cmd[2:0]==3'b111).
- Single command: in_cmd=7'b0001110, d1=8'h0F, d2=8'h12, d3=8'hF0, tag=1 → out_valid 3 edges after acceptance, out_result=16'h12FF, out_zero=0, out_error=0, out_tag=1.
- FIFO fill with out_ready=0: push 6 commands back-to-back →
  - in_ready drops after 4 accepted while the first command is in WAIT/RESP;
  - draining returns tags 0,1,2,3 in order;
  - busy=0 only after the last result is accepted.
- Backpressure: hold out_ready=0 for 10 cycles in RESP → out_* stable, proc_cmd=NOP_CMD, no second issue; releasing out_ready completes the next command after PROC_LAT+1 further edges.
- Error counting:
  - 3 commands with cmd[2:0]=3'b111 → err_count=3, out_error=1 on each;
  - d1=d3=8'h00 with d2=0 → out_zero=1.
  - Preload 255 errors (forced counter) → stays at 255.
- Reset mid-operation: assert rst in WAIT with 2 entries queued → next cycle state IDLE, FIFO empty, out_valid=0, err_count=0, proc_cmd=NOP_CMD; no stale result appears afterwards.
- Wrap-around: stream 20 random commands with out_ready=1 → every result matches the stub model in order, and pointer wrap causes no loss or duplication.
